ahb_lite_master: RTL and testbench
==================================

# ahb_lite_master

AHB-Lite bus master that turns a simple valid/ready command stream into pipelined AHB-Lite transfers and returns per-transfer responses. It sits directly upstream of the memory slaves on the AHB-Lite fabric. It drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA and consumes HRDATA/HREADY/HRESP. It supports wait states, the two-cycle ERROR response with automatic replay of the pending address phase, and a bounded response FIFO with backpressure.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RSP_DEPTH, 4, response FIFO entries; minimum 3 for one transfer per cycle
- HCLK  in  1  bus clock, all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high at a rising edge
- cmd_addr  in  ADDR_W  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  HSIZE code; caller guarantees natural alignment
- cmd_wdata  in  DATA_W  write data, ignored for reads
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors
- rsp_err  out  1  1 = slave returned ERROR
- HADDR, HTRANS, HWRITE, HSIZE, HBURST  out  ADDR_W, 2, 1, 3, 3  address-phase signals, registered
- HWDATA  out  DATA_W  data-phase write data, registered
- HREADY  in  1  bus ready (mux of slave HREADYOUT)
- HRDATA  in  DATA_W  read data
- HRESP  in  1  0 = OKAY, 1 = ERROR

## Operation
- Two pipeline registers:
  - A (address stage): valid, addr, write, size, wdata.
  - D (data stage): valid, write, wdata.
- A drives HADDR/HWRITE/HSIZE/HBURST. HTRANS = NONSEQ (or SEQ, see Configuration) when A.valid and not masked, else IDLE. HWDATA = D.wdata.
- Edge with HREADY=1: D <= A (when HTRANS ≠ IDLE), else D.valid <= 0. A <= accepted command, else A.valid <= 0.
- Edge with HREADY=0: A and D hold. All bus outputs stay stable.
- Completion: edge with HREADY=1 and D.valid pushes {rdata = D.write ? 0 : HRDATA, err = HRESP} into the FIFO. An errored read returns rdata = 0.
- cmd_ready = HRESETn && !err_mask && (!A.valid || HREADY) && (A.valid + D.valid + fifo_count − pop) < RSP_DEPTH, where pop = rsp_valid && rsp_ready. This guarantees the FIFO never overflows.
- ERROR handling. err_mask = D.valid && HRESP.
  - While err_mask is set, HTRANS is forced to IDLE in both ERROR cycles.
  - A is not advanced at the second-cycle edge, so the pending command is replayed as NONSEQ the next cycle.
  - Exactly one response with err=1 is produced per errored transfer.
- IDLE → NONSEQ is permitted during a wait state (A empty, HREADY=0).

## Timing
- Command accepted at edge N:
  - address phase in cycle N+1;
  - data phase in N+2 (zero wait);
  - rsp_valid in N+3.
- Latency: 3 cycles plus wait states. Throughput: 1 transfer per cycle with HREADY=1 and rsp_ready=1.
- Reset values:
  - HADDR=0, HTRANS=IDLE(00), HWRITE=0, HSIZE=000, HBURST=000, HWDATA=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0;
  - A, D and the FIFO empty.
- Reset asserted mid-operation: all in-flight transfers are dropped with no response. The bus is IDLE on the first cycle after release.
- FIFO full and rsp_ready=0: cmd_ready low. Completions already in flight still fit by construction.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

## Configuration
- AHB_MASTER_SEQ_EN defined:
  - A command is a SEQ beat when all of the following hold: it is accepted in the cycle immediately after the previous beat's address phase completes, it has the same write/size, its addr = prev addr + (1 << size), and it does not cross a 1 KB boundary.
  - SEQ beats drive HTRANS=SEQ; the first beat of each run is NONSEQ.
  - HBURST = INCR (001) for every beat.
  - A replay after ERROR restarts the run with NONSEQ.
- AHB_MASTER_SEQ_EN undefined: every transfer is NONSEQ with HBURST = SINGLE (000). The sequence-detect logic is absent.

## Structure
- Package ahb_lite_pkg:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HBURST codes (SINGLE, INCR);
  - HSIZE codes (BYTE, HALF, WORD);
  - HRESP codes (OKAY, ERROR);
  - typedef ahb_rsp_t {rdata, err}.
- Sub-module ahb_rsp_fifo: synchronous FIFO parameterised by depth and payload type, exposing count.

## Test plan
- Write 0x10 ← 0xA5A50001 then read 0x10 with HREADY=1 → HTRANS NONSEQ at N+1, HWDATA 0xA5A50001 at N+2, write rsp err=0 rdata=0, read rsp rdata = 0xA5A50001 from the slave model.
- Four back-to-back word writes to 0x0, 0x4, 0x8, 0xC → four consecutive address phases. HTRANS is NONSEQ,SEQ,SEQ,SEQ with HBURST=001 under AHB_MASTER_SEQ_EN, otherwise all NONSEQ with HBURST=000.
- Slave holds HREADY=0 for 2 cycles in a write data phase with the next read in the address phase → HADDR/HTRANS/HWDATA stable for 3 cycles, cmd_ready=0, responses in order.
- Read 0x4000 answered with a two-cycle ERROR while write 0x20 is pending → HTRANS IDLE in both ERROR cycles, rsp err=1 rdata=0, then 0x20 is reissued NONSEQ on the next cycle.
- rsp_ready=0 with 6 commands offered → exactly RSP_DEPTH accepted, then cmd_ready=0. Raising rsp_ready drains all responses in order, with no loss and no duplicates.
- HRESETn pulsed low with 2 transfers in flight → all outputs return to reset values at once, no response emitted, bus IDLE after release.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the response payload type used by the
// master and its response FIFO.
package ahb_lite_pkg;

  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] rdata;
    logic                  err;
  } ahb_rsp_t;

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Synchronous response FIFO, any depth, generic payload type; exposes its
// occupancy so the master can reserve room for in-flight transfers.
module ahb_rsp_fifo import ahb_lite_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = ahb_rsp_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  T                 mem [DEPTH];

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: valid/ready commands in, pipelined transfers out, ordered
// responses back. Define AHB_MASTER_SEQ_EN to merge sequential beats into INCR runs.
module ahb_lite_master import ahb_lite_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  logic              vld_p0, write_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        size_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              vld_p1, write_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              err_mask, accept, push, pop, fifo_empty, beat_seq, issue;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occ;
  ahb_rsp_t          push_rsp, head_rsp;

  assign err_mask = vld_p1 && (HRESP == HRESP_ERROR);
  assign issue    = vld_p0 && !err_mask;
  assign pop      = rsp_valid && rsp_ready;
  assign push     = HREADY && vld_p1;
  assign accept   = cmd_valid && cmd_ready;

  // Every transfer in A or D already owns a FIFO slot, so completions never overflow.
  assign occ = OCC_W'(vld_p0) + OCC_W'(vld_p1) + OCC_W'(fifo_count) - OCC_W'(pop);
  assign cmd_ready = HRESETn && !err_mask && (!vld_p0 || HREADY) &&
                     (occ < OCC_W'(RSP_DEPTH));

`ifdef AHB_MASTER_SEQ_EN
  logic seq_p0;
  logic cmd_seq;

  assign cmd_seq = vld_p0 && HREADY && !err_mask &&
                   (cmd_write == write_p0) && (cmd_size == size_p0) &&
                   (cmd_addr == addr_p0 + (ADDR_W'(1) << size_p0)) &&
                   (cmd_addr[ADDR_W-1:10] == addr_p0[ADDR_W-1:10]);

  // An ERROR breaks the run: the replayed beat goes out as NONSEQ.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      seq_p0 <= 1'b0;
    else if (err_mask) seq_p0 <= 1'b0;
    else if (accept)   seq_p0 <= cmd_seq;
  end

  assign beat_seq = seq_p0;
  assign HBURST   = HBURST_INCR;
`else
  assign beat_seq = 1'b0;
  assign HBURST   = HBURST_SINGLE;
`endif

  // Stage p0: address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      size_p0  <= '0;
    end else if (accept) begin
      vld_p0   <= 1'b1;
      addr_p0  <= cmd_addr;
      write_p0 <= cmd_write;
      size_p0  <= cmd_size;
    end else if (HREADY && !err_mask) begin
      vld_p0   <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) wdata_p0 <= cmd_wdata;
  end

  // Stage p1: data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      wdata_p1 <= '0;
    end else if (HREADY) begin
      vld_p1 <= issue;
      if (issue) begin
        write_p1 <= write_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  always_comb begin
    HTRANS = HTRANS_IDLE;
    if (issue) HTRANS = beat_seq ? HTRANS_SEQ : HTRANS_NONSEQ;
  end

  assign HADDR  = addr_p0;
  assign HWRITE = write_p0;
  assign HSIZE  = size_p0;
  assign HWDATA = wdata_p1;

  // Stage p2: response queue
  always_comb begin
    push_rsp       = '0;
    push_rsp.rdata = (write_p1 || HRESP) ? '0 : HRDATA;
    push_rsp.err   = HRESP;
  end

  ahb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (ahb_rsp_t)
  ) u_rsp_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .din     (push_rsp),
    .pop     (pop),
    .dout    (head_rsp),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? head_rsp.rdata : '0;
  assign rsp_err   = rsp_valid && head_rsp.err;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small memory slave whose
// HREADY/HRESP are scripted cycle by cycle.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int RSP_DEPTH = 4;

`ifdef AHB_MASTER_SEQ_EN
  localparam logic [1:0] EXP_SEQ   = 2'b11;
  localparam logic [2:0] EXP_BURST = 3'b001;
`else
  localparam logic [1:0] EXP_SEQ   = 2'b10;
  localparam logic [2:0] EXP_BURST = 3'b000;
`endif

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE, HBURST;
  logic [DATA_W-1:0] HWDATA, HRDATA;
  logic              HREADY, HRESP;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  // Memory slave: 64 words, returns data during the read data phase.
  logic [31:0] mem [64];
  logic        dp_vld, dp_write;
  logic [5:0]  dp_idx;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_vld <= 1'b0;
    end else if (HREADY) begin
      if (dp_vld && dp_write) mem[dp_idx] <= HWDATA;
      dp_vld   <= HTRANS[1];
      dp_write <= HWRITE;
      dp_idx   <= HADDR[7:2];
    end
  end

  assign HRDATA = (dp_vld && !dp_write) ? mem[dp_idx] : 32'h0;

  logic [32:0] rsp_q [$];
  always @(posedge HCLK) begin
    if (HRESETn && rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_rdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_size  = 3'b010;
  endtask

  logic [31:0] w2 [4];
  int          n_acc;
  logic        rdy;

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; rsp_ready = 1'b1;
    set_cmd(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) w2[i] = 32'h1000_0000 + 32'(i) * 32'h0101;

    // Reset state
    cyc(); cyc();
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_hburst", HBURST, EXP_BURST);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    HRESETn = 1'b1;
    cyc();

    // Write then read of 0x10
    set_cmd(1, 1, 32'h10, 32'hA5A5_0001); #1;
    check("t1_cmd_ready", cmd_ready, 1);
    cyc();
    set_cmd(1, 0, 32'h10, 0); #1;
    check("t1_wr_htrans", HTRANS, 2'b10);
    check("t1_wr_haddr", HADDR, 32'h10);
    check("t1_wr_hwrite", HWRITE, 1);
    check("t1_wr_hsize", HSIZE, 3'b010);
    check("t1_hburst", HBURST, EXP_BURST);
    cyc();
    set_cmd(0, 0, 0, 0); #1;
    check("t1_hwdata", HWDATA, 32'hA5A5_0001);
    check("t1_rd_htrans", HTRANS, 2'b10);
    check("t1_rd_hwrite", HWRITE, 0);
    cyc();
    check("t1_wr_rsp_valid", rsp_valid, 1);
    check("t1_wr_rsp", {rsp_err, rsp_rdata}, 33'h0);
    check("t1_idle", HTRANS, 2'b00);
    cyc();
    check("t1_rd_rsp_valid", rsp_valid, 1);
    check("t1_rd_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'hA5A5_0001});
    cyc(); cyc();

    // Four back-to-back word writes
    rsp_q.delete();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_cmd(1, 1, 32'(i * 4), w2[i]);
      else       set_cmd(0, 0, 0, 0);
      #1;
      if (i < 4) check($sformatf("t2_cmd_ready%0d", i), cmd_ready, 1);
      if (i > 0) begin
        check($sformatf("t2_htrans%0d", i - 1), HTRANS, (i == 1) ? 2'b10 : EXP_SEQ);
        check($sformatf("t2_haddr%0d", i - 1), HADDR, 32'((i - 1) * 4));
        check($sformatf("t2_hburst%0d", i - 1), HBURST, EXP_BURST);
      end
      cyc();
    end
    repeat (4) cyc();
    check("t2_rsp_count", rsp_q.size(), 4);

    // Two wait states in a write data phase with a read in the address phase
    rsp_q.delete();
    set_cmd(1, 1, 32'h30, 32'h1111_2222);
    cyc();
    set_cmd(1, 0, 32'h30, 0);
    cyc();
    set_cmd(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      HREADY = (i == 2);
      #1;
      check($sformatf("t3_haddr%0d", i), HADDR, 32'h30);
      check($sformatf("t3_htrans%0d", i), HTRANS, 2'b10);
      check($sformatf("t3_hwdata%0d", i), HWDATA, 32'h1111_2222);
      if (i < 2) check($sformatf("t3_cmd_ready%0d", i), cmd_ready, 0);
      cyc();
    end
    HREADY = 1'b1;
    repeat (3) cyc();
    check("t3_rsp_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      check("t3_rsp0", rsp_q[0], 33'h0);
      check("t3_rsp1", rsp_q[1], {1'b0, 32'h1111_2222});
    end

    // Two-cycle ERROR on a read with a write pending
    rsp_q.delete();
    set_cmd(1, 0, 32'h4000, 0);
    cyc();
    set_cmd(1, 1, 32'h20, 32'hBEEF_0020); #1;
    check("t4_rd_htrans", HTRANS, 2'b10);
    check("t4_rd_haddr", HADDR, 32'h4000);
    cyc();
    set_cmd(0, 0, 0, 0);
    HREADY = 1'b0; HRESP = 1'b1; #1;
    check("t4_err1_htrans", HTRANS, 2'b00);
    check("t4_err1_cmd_ready", cmd_ready, 0);
    cyc();
    HREADY = 1'b1; HRESP = 1'b1; #1;
    check("t4_err2_htrans", HTRANS, 2'b00);
    cyc();
    HRESP = 1'b0; #1;
    check("t4_replay_htrans", HTRANS, 2'b10);
    check("t4_replay_haddr", HADDR, 32'h20);
    check("t4_replay_hwrite", HWRITE, 1);
    check("t4_err_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0});
    cyc();
    check("t4_hwdata", HWDATA, 32'hBEEF_0020);
    repeat (3) cyc();
    check("t4_rsp_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      check("t4_rsp0", rsp_q[0], {1'b1, 32'h0});
      check("t4_rsp1", rsp_q[1], 33'h0);
    end

    // Backpressure: rsp_ready low, six reads offered
    rsp_q.delete();
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 12 && n_acc < 6; k++) begin
      set_cmd(1, 0, 32'(n_acc * 4), 0); #1;
      rdy = cmd_ready;
      cyc();
      if (rdy) n_acc++;
    end
    #1;
    check("t5_accepted", n_acc, RSP_DEPTH);
    check("t5_cmd_ready", cmd_ready, 0);
    check("t5_rsp_valid", rsp_valid, 1);
    set_cmd(0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (8) cyc();
    check("t5_rsp_count", rsp_q.size(), RSP_DEPTH);
    for (int i = 0; i < 4; i++)
      if (i < rsp_q.size()) check($sformatf("t5_rsp%0d", i), rsp_q[i], {1'b0, w2[i]});

    // Reset with two transfers in flight
    rsp_q.delete();
    set_cmd(1, 1, 32'h60, 32'h6060_6060);
    cyc();
    set_cmd(1, 1, 32'h64, 32'h6464_6464);
    cyc();
    set_cmd(0, 0, 0, 0);
    HRESETn = 1'b0; #1;
    check("t6_htrans", HTRANS, 2'b00);
    check("t6_haddr", HADDR, 0);
    check("t6_hwdata", HWDATA, 0);
    check("t6_hwrite", HWRITE, 0);
    check("t6_cmd_ready", cmd_ready, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    cyc();
    HRESETn = 1'b1; #1;
    check("t6_post_htrans", HTRANS, 2'b00);
    check("t6_post_rsp_valid", rsp_valid, 0);
    repeat (3) cyc();
    check("t6_rsp_count", rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
